// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the packet-granular uart_tx arbiter and its picker.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo NUM_REQ.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        // Scan from the far end so the offset closest to ptr is the one left standing.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'(wrap_add(int'(ptr), k, NUM_REQ));
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte stream between NUM_REQ AXI-Stream producers, holding
// each grant until tlast (or an idle timeout) so packets never interleave.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ID_W           = clog2_min1(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]   s_tvalid,
    input  logic [NUM_REQ-1:0]   s_tlast,
    output logic [NUM_REQ-1:0]   s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 timeout_pulse
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [31:0]     idle_cnt_q, idle_cnt_d;
    logic            timeout_pulse_q, timeout_pulse_d;

    logic [ID_W-1:0] pick;
    logic            any_req;
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic [ID_W-1:0] next_ptr;
    logic            timeout_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req  (s_tvalid),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_data  = s_tdata[8*i +: 8];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Wrap against NUM_REQ-1 so non-power-of-two requester counts rotate correctly.
    assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !sel_valid &&
                         (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ARB_IDLE;
            rr_ptr_q        <= '0;
            grant_id_q      <= '0;
            idle_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            idle_cnt_q      <= idle_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        idle_cnt_d      = idle_cnt_q;
        timeout_pulse_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_id_d = pick;
                    idle_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (sel_valid) begin
                    idle_cnt_d = '0;
                    if (m_tready && sel_last) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else begin
                    if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + 32'd1;
                    end
                    if (timeout_hit) begin
                        state_d         = ARB_IDLE;
                        rr_ptr_d        = next_ptr;
                        timeout_pulse_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    assign grant_valid   = (state_q == ARB_GRANT);
    assign grant_id      = grant_id_q;
    assign timeout_pulse = timeout_pulse_q;
    assign m_tdata       = grant_valid ? sel_data : 8'h00;
    assign m_tvalid      = grant_valid && sel_valid;
    assign m_tlast       = grant_valid && sel_last;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign s_tready[gi] = grant_valid && m_tready && (grant_id_q == ID_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized packet run checked against a rule-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tlast;
    logic [N-1:0]  s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          timeout_pulse;

    int tests = 0;
    int fails = 0;

    logic [8:0] pq [N][$];
    int         gap [N];
    int         owner;
    int         ptr_m;
    int         cyc;
    int         npk;
    int         len;
    bit         fire;
    bit         done;
    logic [8:0] head;
    logic [3:0] exp_rdy;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        s_tvalid = 4'b1111;
        s_tlast  = '0;
        s_tdata  = 32'hA1B2C3D4;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant_valid", grant_valid, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_timeout_pulse", timeout_pulse, 0);
        check("rst_grant_id", grant_id, 0);
        $display("[TB] reset state checked");
        do_reset();

        // Single requester 1, 3-byte packet.
        step();
        s_tvalid = 4'b0010; s_tdata[15:8] = 8'h41; s_tlast = 4'b0000;
        smp();
        check("t1_sel_cycle_idle", grant_valid, 0);
        check("t1_sel_cycle_mvalid", m_tvalid, 0);
        step();
        smp();
        check("t1_grant_valid", grant_valid, 1);
        check("t1_grant_id", grant_id, 1);
        check("t1_b0_data", m_tdata, 8'h41);
        check("t1_b0_valid", m_tvalid, 1);
        check("t1_s_tready", s_tready, 4'b0010);
        step();
        s_tdata[15:8] = 8'h42;
        smp();
        check("t1_b1_data", m_tdata, 8'h42);
        check("t1_b1_last", m_tlast, 0);
        step();
        s_tdata[15:8] = 8'h43; s_tlast = 4'b0010;
        smp();
        check("t1_b2_data", m_tdata, 8'h43);
        check("t1_b2_last", m_tlast, 1);
        step();
        s_tvalid = 4'b1101; s_tlast = 4'b1101;
        smp();
        check("t1_release", grant_valid, 0);
        step();
        smp();
        check("t1_rr_ptr_after", grant_id, 2);
        $display("[TB] single requester packet checked");
        do_reset();

        // Requesters 0 and 2 together, 2-byte packets each.
        step();
        s_tvalid = 4'b0101; s_tdata = 32'h00C0_00A0; s_tlast = 4'b0000;
        smp();
        check("t2_idle", grant_valid, 0);
        step();
        smp();
        check("t2_g0_id", grant_id, 0);
        check("t2_g0_b0", m_tdata, 8'hA0);
        check("t2_g0_rdy", s_tready, 4'b0001);
        step();
        s_tdata[7:0] = 8'hA1; s_tlast = 4'b0001;
        smp();
        check("t2_g0_b1", m_tdata, 8'hA1);
        check("t2_g0_rdy2", s_tready, 4'b0001);
        step();
        s_tvalid = 4'b0100; s_tlast = 4'b0000;
        smp();
        check("t2_gap_idle", grant_valid, 0);
        step();
        smp();
        check("t2_g2_id", grant_id, 2);
        check("t2_g2_b0", m_tdata, 8'hC0);
        check("t2_g2_rdy", s_tready, 4'b0100);
        step();
        s_tdata[23:16] = 8'hC1; s_tlast = 4'b0100;
        smp();
        check("t2_g2_b1", m_tdata, 8'hC1);
        check("t2_g2_last", m_tlast, 1);
        step();
        s_tvalid = '0;
        smp();
        check("t2_done_idle", grant_valid, 0);
        $display("[TB] two-requester no-interleave checked");
        do_reset();

        // Timeout: requester 3 sends one byte without tlast, then goes quiet.
        step();
        s_tvalid = 4'b1000; s_tdata[31:24] = 8'h77; s_tlast = '0;
        smp();
        step();
        smp();
        check("t4_grant_id", grant_id, 3);
        check("t4_byte", m_tdata, 8'h77);
        step();
        s_tvalid = '0;
        for (int k = 0; k < 8; k++) begin
            smp();
            check("t4_no_pulse_yet", timeout_pulse, 0);
            check("t4_still_granted", grant_valid, 1);
            step();
        end
        s_tvalid = 4'b1011; s_tlast = 4'b1011;
        smp();
        check("t4_pulse", timeout_pulse, 1);
        check("t4_released", grant_valid, 0);
        step();
        smp();
        check("t4_pulse_one_cycle", timeout_pulse, 0);
        check("t4_next_grant", grant_id, 0);
        check("t4_next_valid", grant_valid, 1);
        $display("[TB] idle timeout checked");
        do_reset();

        // Backpressure for 50 cycles mid-packet must not time out.
        step();
        s_tvalid = 4'b0010; s_tdata[15:8] = 8'h61; s_tlast = '0;
        smp();
        step();
        smp();
        check("t5_b0", m_tdata, 8'h61);
        step();
        s_tdata[15:8] = 8'h62; m_tready = 1'b0;
        for (int k = 0; k < 50; k++) begin
            smp();
            check("t5_hold_pulse", timeout_pulse, 0);
            check("t5_hold_grant", grant_valid, 1);
            check("t5_hold_rdy", s_tready, 0);
            check("t5_hold_data", m_tdata, 8'h62);
            step();
        end
        m_tready = 1'b1;
        smp();
        check("t5_b1", m_tdata, 8'h62);
        check("t5_b1_rdy", s_tready, 4'b0010);
        step();
        s_tdata[15:8] = 8'h63; s_tlast = 4'b0010;
        smp();
        check("t5_b2", m_tdata, 8'h63);
        check("t5_b2_last", m_tlast, 1);
        step();
        s_tvalid = '0;
        smp();
        check("t5_end_idle", grant_valid, 0);
        check("t5_end_pulse", timeout_pulse, 0);
        $display("[TB] backpressure without timeout checked");

        // Reset mid-packet, then continuous 1-byte packets from all four requesters.
        step();
        s_tvalid = 4'b0100; s_tdata[23:16] = 8'h55; s_tlast = '0;
        smp();
        step();
        smp();
        check("t6_granted", grant_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_grant", grant_valid, 0);
        check("t6_async_mvalid", m_tvalid, 0);
        check("t6_async_rdy", s_tready, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        s_tvalid = 4'b1111; s_tlast = 4'b1111; s_tdata = 32'hD3D2D1D0;
        for (int k = 0; k < 6; k++) begin
            smp();
            check("t3_idle_between", grant_valid, 0);
            step();
            smp();
            check("t3_order", grant_id, k % 4);
            check("t3_data", m_tdata, 8'hD0 + 8'(k % 4));
            step();
        end
        s_tvalid = '0;
        $display("[TB] reset restart and rotation checked");
        do_reset();

        // Randomized packets with random backpressure and short in-packet gaps.
        for (int i = 0; i < N; i++) begin
            npk = $urandom_range(3, 6);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    pq[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            gap[i] = $urandom_range(0, 5);
        end
        owner = -1; ptr_m = 0; fire = 0; done = 0; cyc = 0;
        while (!done && cyc < 20000) begin
            step();
            cyc++;
            if (fire) begin
                head = pq[owner].pop_front();
                $display("[TB] req%0d byte 0x%02h last=%0d", owner, head[7:0], head[8]);
                if (head[8]) begin
                    ptr_m      = (owner + 1) % N;
                    gap[owner] = $urandom_range(0, 6);
                    owner      = -1;
                end else begin
                    gap[owner] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                end
                fire = 0;
            end
            m_tready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                    s_tvalid[i] = 1'b0;
                end else begin
                    s_tvalid[i] = (pq[i].size() > 0);
                end
                if (pq[i].size() > 0) begin
                    {s_tlast[i], s_tdata[8*i +: 8]} = pq[i][0];
                end else begin
                    s_tlast[i] = 1'b0;
                    s_tdata[8*i +: 8] = 8'($urandom);
                end
            end
            smp();
            check("rnd_pulse", timeout_pulse, 0);
            if (owner < 0) begin
                check("rnd_idle_grant", grant_valid, 0);
                check("rnd_idle_mvalid", m_tvalid, 0);
                check("rnd_idle_rdy", s_tready, 0);
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && s_tvalid[(ptr_m + k) % N]) owner = (ptr_m + k) % N;
                end
            end else begin
                exp_rdy = m_tready ? (4'b0001 << owner) : 4'b0000;
                check("rnd_grant_valid", grant_valid, 1);
                check("rnd_grant_id", grant_id, owner);
                check("rnd_rdy", s_tready, exp_rdy);
                check("rnd_mvalid", m_tvalid, s_tvalid[owner]);
                if (s_tvalid[owner]) begin
                    check("rnd_data", m_tdata, pq[owner][0][7:0]);
                    check("rnd_last", m_tlast, pq[owner][0][8]);
                    fire = m_tready;
                end
            end
            done = (owner < 0);
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() > 0) done = 0;
            end
        end
        check("rnd_drain_in_budget", done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one uart_tx byte stream between NUM_REQ AXI-Stream byte producers.
- Sits between the producers (debug printer, telemetry, command echo, etc.) and the sink port of uart_tx.
- Holds a grant until tlast or an idle timeout, so messages from different producers never interleave on the wire.

Parameters:
- NUM_REQ, 4, number of requester streams (1..16).
- TIMEOUT_CYCLES, 100000, consecutive cycles with the granted tvalid low, mid-packet, before the grant is forcibly released; 0 disables the timeout.
- ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), width of grant_id (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- s_tdata  in  NUM_REQ*8  requester bytes; requester i occupies bits [8i+7:8i].
- s_tvalid  in  NUM_REQ  per-requester valid.
- s_tlast  in  NUM_REQ  per-requester end of packet.
- s_tready  out  NUM_REQ  per-requester ready.
- m_tdata  out  8  byte to uart_tx sink.
- m_tvalid  out  1  valid to uart_tx.
- m_tlast  out  1  forwarded tlast.
- m_tready  in  1  ready from uart_tx.
- grant_valid  out  1  a requester currently owns the output.
- grant_id  out  ID_W  index of the owner; holds the last owner when grant_valid=0.
- timeout_pulse  out  1  one-cycle pulse when a grant is released by timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - Registers: state=ARB_IDLE, rr_ptr=0, grant_id=0, idle_cnt=0, timeout_pulse=0.
  - Outputs: grant_valid=0, m_tvalid=0, s_tready=0.
  - Release is synchronous to clk.
- ARB_IDLE:
  - m_tvalid=0, all s_tready=0.
  - If any s_tvalid is high, pick the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register grant_id=pick, go to ARB_GRANT, clear idle_cnt.
  - No transfer happens in the selection cycle: the first byte can move 1 cycle after a request is seen.
- ARB_GRANT (g = grant_id):
  - Outputs: grant_valid=1; m_tdata/m_tvalid/m_tlast = s_tdata[g]/s_tvalid[g]/s_tlast[g] (combinational mux); s_tready[g]=m_tready; every other s_tready=0.
  - Transfer condition: s_tvalid[g] && m_tready.
  - Transfer with s_tlast[g]=1: next state ARB_IDLE, rr_ptr = (g+1) mod NUM_REQ, and the grant drops the following cycle.
  - idle_cnt: cleared while s_tvalid[g]=1; incremented (saturating) while s_tvalid[g]=0.
  - Timeout: if TIMEOUT_CYCLES!=0 and idle_cnt reaches TIMEOUT_CYCLES-1 with s_tvalid[g] still 0, then next state ARB_IDLE, rr_ptr = g+1 mod NUM_REQ, timeout_pulse=1 for one cycle.
  - m_tready low does not advance idle_cnt while valid is held.
- Arbitration rules:
  - Non-granted requesters never see s_tready=1.
  - Back-to-back packets from the same requester are granted consecutively only if no other requester is valid in the ARB_IDLE cycle.
- Simultaneous events:
  - tlast transfer and the timeout threshold in the same cycle: tlast wins, no pulse.
  - A new request arriving on the release cycle is seen on the following ARB_IDLE cycle.
- Minimum turnaround between packets: 1 idle cycle (ARB_IDLE). This is acceptable because each uart_tx byte lasts 10*CLKS_PER_BIT cycles.
- AXIS compliance: the block never drops a byte; m_tvalid changes only with s_tvalid[g] or on grant change. On a timeout release, a requester that later raises tvalid re-arbitrates normally and its packet remainder is sent as a new grant.
- Widths:
  - idle_cnt is 32 bits and saturating.
  - rr_ptr wrap: compare against NUM_REQ-1, not a power of two.
  - NUM_REQ=1: grant_id is constantly 0, and rotation is a no-op.
- Reset mid-packet: the grant is dropped immediately and the byte in flight is lost. uart_tx behaviour is unaffected beyond its own input FIFO.

Decomposition:
- Package uart_arb_pkg holds:
  - the typedef enum arb_state_t {ARB_IDLE, ARB_GRANT};
  - the function clog2_min1(n) used for ID_W.
- Sub-module rr_picker: combinational. Inputs req[NUM_REQ] and ptr; outputs pick[ID_W] and any. It is reused later by other shared-peripheral arbiters.

Test Plan:
- Single requester 1 sends 3-byte packet 0x41,0x42,0x43 (tlast on 0x43), m_tready=1 → m_tdata sequence 41,42,43 with m_tlast on 43; first byte transfers the cycle after s_tvalid rises; grant_id=1; rr_ptr=2 after.
- Requesters 0 and 2 both valid at the same cycle from reset, each with a 2-byte packet → req0 bytes fully before req2 bytes; no interleave; s_tready[2]=0 throughout req0's packet.
- All 4 requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0,1; one ARB_IDLE cycle between grants.
- TIMEOUT_CYCLES=8; requester 3 sends 1 byte without tlast, then drops tvalid → timeout_pulse high for exactly 1 cycle, 8 cycles after tvalid fell; then grant_valid=0 and requester 0 is granted next if valid.
- m_tready held low 50 cycles mid-packet with s_tvalid high, TIMEOUT_CYCLES=8 → no timeout; bytes delivered unchanged once ready returns.
- Assert reset low mid-packet for 1 cycle → grant_valid, m_tvalid and s_tready go 0 asynchronously; after release, rr_ptr=0 and arbitration restarts from requester 0.
